i2c_master_byte: RTL and testbench

//  Single-clock I2C controller (initiator) that runs one transaction per request:

---
 rtl/i2c_pkg.sv | 26 ++
 rtl/i2c_tick_gen.sv | 36 +++
 rtl/i2c_master_byte.sv | 173 +++++++++++++++++
 tb/tb_i2c_master_byte.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: controller state encoding and bit-slot quarter phases.
// Also used by the slave-side bench.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    ACK1,
    DATA,
    ACK2,
    STOP,
    DONE
  } i2c_state_e;

  localparam logic [1:0] QTR_DRIVE  = 2'd0;
  localparam logic [1:0] QTR_RISE   = 2'd1;
  localparam logic [1:0] QTR_SAMPLE = 2'd2;
  localparam logic [1:0] QTR_FALL   = 2'd3;

  // SCL is held low in the first and last quarter of every ordinary bit slot.
  function automatic logic scl_low_phase(input logic [1:0] q);
    return (q == QTR_DRIVE) || (q == QTR_FALL);
  endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-period tick generator: one tick every CLK_DIV cycles plus a 2-bit quarter index.
// The count holds while freeze is high so a slave can stretch the SCL low phase.
module i2c_tick_gen
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       freeze,
  output logic       tick,
  output logic [1:0] quarter
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] count_reg;
  logic [1:0]    quarter_reg;

  assign tick    = !freeze && (count_reg == CW'(CLK_DIV - 1));
  assign quarter = quarter_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg   <= '0;
      quarter_reg <= QTR_DRIVE;
    end else if (tick) begin
      count_reg   <= '0;
      quarter_reg <= quarter_reg + 2'd1;
    end else if (!freeze) begin
      count_reg <= count_reg + CW'(1);
    end
  end

endmodule

// File: rtl/i2c_master_byte.sv
// Single-byte I2C initiator: START, {addr,rw}, one data byte, STOP.
// Drives the open-drain bus through registered output-enables.
module i2c_master_byte
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_in,
  input  logic       sda_in
);

  i2c_state_e state_reg, state_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0] shift_reg, shift_next;
  logic [7:0] wdata_reg, wdata_next;
  logic [7:0] rdata_reg, rdata_next;
  logic       rw_reg, rw_next;
  logic       ack_err_reg, ack_err_next;
  logic       scl_oe_reg, scl_oe_next;
  logic       sda_oe_reg, sda_oe_next;
  logic       tick, accept, freeze, slot_end, sample_pt;
  logic [1:0] quarter, quarter_next;

  assign busy      = (state_reg != IDLE) && (state_reg != DONE);
  assign done      = (state_reg == DONE);
  assign accept    = start && !busy;
  assign freeze    = busy && (quarter == QTR_RISE) && !scl_in;
  assign slot_end  = tick && (quarter == QTR_FALL);
  assign sample_pt = tick && (quarter == QTR_SAMPLE);
  // Mirrors the tick generator's quarter register so outputs can be registered in phase.
  assign quarter_next = accept ? QTR_DRIVE : (tick ? quarter + 2'd1 : quarter);

  assign rdata   = rdata_reg;
  assign ack_err = ack_err_reg;
  assign scl_oe  = scl_oe_reg;
  assign sda_oe  = sda_oe_reg;

  i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept),
    .freeze  (freeze),
    .tick    (tick),
    .quarter (quarter)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      wdata_reg   <= '0;
      rdata_reg   <= '0;
      rw_reg      <= 1'b0;
      ack_err_reg <= 1'b0;
      scl_oe_reg  <= 1'b0;
      sda_oe_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      wdata_reg   <= wdata_next;
      rdata_reg   <= rdata_next;
      rw_reg      <= rw_next;
      ack_err_reg <= ack_err_next;
      scl_oe_reg  <= scl_oe_next;
      sda_oe_reg  <= sda_oe_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    wdata_next   = wdata_reg;
    rdata_next   = rdata_reg;
    rw_next      = rw_reg;
    ack_err_next = ack_err_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next   = START;
          shift_next   = {addr, rw};
          wdata_next   = wdata;
          rw_next      = rw;
          ack_err_next = 1'b0;
          bit_cnt_next = '0;
        end else begin
          state_next = IDLE;
        end
      end
      START: if (slot_end) state_next = ADDR;
      ADDR: begin
        if (slot_end) begin
          shift_next   = {shift_reg[6:0], 1'b0};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) state_next = ACK1;
        end
      end
      ACK1: begin
        if (sample_pt && sda_in) ack_err_next = 1'b1;
        if (slot_end) begin
          if (ack_err_reg) begin
            state_next = STOP;
          end else begin
            state_next   = DATA;
            shift_next   = rw_reg ? 8'h00 : wdata_reg;
            bit_cnt_next = '0;
          end
        end
      end
      DATA: begin
        if (rw_reg && sample_pt) begin
          shift_next = {shift_reg[6:0], sda_in};
          if (bit_cnt_reg == 3'd7) rdata_next = {shift_reg[6:0], sda_in};
        end
        if (slot_end) begin
          if (!rw_reg) shift_next = {shift_reg[6:0], 1'b0};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) state_next = ACK2;
        end
      end
      ACK2: begin
        if (sample_pt && !rw_reg && sda_in) ack_err_next = 1'b1;
        if (slot_end) state_next = STOP;
      end
      STOP: if (slot_end) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Bus levels are derived from the upcoming state/quarter so they switch on the tick edge.
  always_comb begin
    scl_oe_next = 1'b0;
    sda_oe_next = 1'b0;
    case (state_next)
      START: begin
        scl_oe_next = (quarter_next == QTR_FALL);
        sda_oe_next = (quarter_next != QTR_DRIVE);
      end
      ADDR: begin
        scl_oe_next = scl_low_phase(quarter_next);
        sda_oe_next = !shift_next[7];
      end
      ACK1, ACK2: scl_oe_next = scl_low_phase(quarter_next);
      DATA: begin
        scl_oe_next = scl_low_phase(quarter_next);
        sda_oe_next = !rw_next && !shift_next[7];
      end
      STOP: begin
        scl_oe_next = (quarter_next == QTR_DRIVE);
        sda_oe_next = (quarter_next != QTR_FALL);
      end
      default: begin
        scl_oe_next = 1'b0;
        sda_oe_next = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_master_byte.sv
// Bench for i2c_master_byte: behavioural slave at 7'h01, a per-cycle bus-waveform model,
// directed scenarios and randomized transactions.
module tb_i2c_master_byte;

  localparam int D = 4;
  localparam logic [6:0] SLAVE_ADDR = 7'h01;

  logic       clk = 1'b0;
  logic       reset, start, rw;
  logic [6:0] addr;
  logic [7:0] wdata, rdata;
  logic       busy, done, ack_err, scl_oe, sda_oe, scl_in, sda_in;
  logic       stretch, slave_pull;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign scl_in = ~(scl_oe | stretch);
  assign sda_in = ~(sda_oe | slave_pull);

  i2c_master_byte #(.CLK_DIV(D)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .rw      (rw),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .busy    (busy),
    .done    (done),
    .ack_err (ack_err),
    .scl_oe  (scl_oe),
    .sda_oe  (sda_oe),
    .scl_in  (scl_in),
    .sda_in  (sda_in)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural slave (oversampled at negedge) ----------------
  typedef enum {S_IDLE, S_ADDR, S_ACKA, S_WR, S_ACKW, S_RD, S_SKIP} sl_e;
  sl_e        sl_st;
  int         sl_bits;
  logic [7:0] sl_sh, io_out;
  logic       sl_read, prev_scl, prev_sda;

  initial begin
    sl_st = S_IDLE; sl_bits = 0; sl_sh = '0; io_out = 8'h00; sl_read = 1'b0;
    slave_pull = 1'b0; prev_scl = 1'b1; prev_sda = 1'b1;
    forever begin
      @(negedge clk);
      if (prev_scl && scl_in && prev_sda && !sda_in) begin
        sl_st = S_ADDR; sl_bits = 0; slave_pull = 1'b0;
      end else if (prev_scl && scl_in && !prev_sda && sda_in) begin
        sl_st = S_IDLE; slave_pull = 1'b0;
      end else if (!prev_scl && scl_in) begin
        if ((sl_st == S_ADDR || sl_st == S_WR) && sl_bits < 8) begin
          sl_sh = {sl_sh[6:0], sda_in}; sl_bits++;
        end else if (sl_st == S_RD) begin
          sl_bits++;
        end
      end else if (prev_scl && !scl_in) begin
        case (sl_st)
          S_ADDR: if (sl_bits == 8) begin
            if (sl_sh[7:1] == SLAVE_ADDR) begin
              slave_pull = 1'b1; sl_read = sl_sh[0]; sl_st = S_ACKA;
            end else begin
              sl_st = S_SKIP;
            end
          end
          S_ACKA: begin
            sl_bits = 0;
            if (sl_read) begin sl_st = S_RD; slave_pull = ~io_out[7]; end
            else begin sl_st = S_WR; slave_pull = 1'b0; end
          end
          S_WR: if (sl_bits == 8) begin io_out = sl_sh; slave_pull = 1'b1; sl_st = S_ACKW; end
          S_ACKW: begin slave_pull = 1'b0; sl_st = S_SKIP; end
          S_RD: begin
            if (sl_bits < 8) slave_pull = ~io_out[3'(7 - sl_bits)];
            else begin slave_pull = 1'b0; sl_st = S_SKIP; end
          end
          default: ;
        endcase
      end
      prev_scl = scl_in; prev_sda = sda_in;
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  // Expected bus drive for quarter k of a transaction that lasts total_q quarters.
  function automatic void wave(input int k, input int total_q, input logic [7:0] ab,
                               input logic [7:0] wb, input logic rd,
                               output logic scl, output logic sda);
    int s, q;
    s = k / 4; q = k % 4;
    scl = (q == 0 || q == 3);
    sda = 1'b0;
    if (s == 0) begin
      scl = (q == 3); sda = (q != 0);
    end else if (s == total_q / 4 - 1) begin
      scl = (q == 0); sda = (q != 3);
    end else if (s <= 8) begin
      sda = ~ab[3'(8 - s)];
    end else if (s >= 10 && s <= 17) begin
      sda = rd ? 1'b0 : ~wb[3'(17 - s)];
    end
  endfunction

  logic       m_active, m_done, m_ack, m_rd, m_nack, e_scl, e_sda;
  logic [7:0] m_abyte, m_wbyte, m_rdata, m_io;
  int         m_eff, m_total, done_count, busy_run, last_run;

  initial begin
    m_active = 0; m_done = 0; m_ack = 0; m_rd = 0; m_nack = 0;
    m_abyte = 0; m_wbyte = 0; m_rdata = 0; m_io = 0;
    m_eff = 0; m_total = 80; done_count = 0; busy_run = 0; last_run = 0;
    forever begin
      @(negedge clk);
      e_scl = 1'b0; e_sda = 1'b0;
      if (m_active) wave(m_eff / D, m_total, m_abyte, m_wbyte, m_rd, e_scl, e_sda);
      chk("busy", 32'(busy), 32'(m_active));
      chk("done", 32'(done), 32'(m_done));
      chk("scl_oe", 32'(scl_oe), 32'(e_scl));
      chk("sda_oe", 32'(sda_oe), 32'(e_sda));
      chk("ack_err", 32'(ack_err), 32'(m_ack));
      if (!m_active) chk("rdata", 32'(rdata), 32'(m_rdata));
      if (done) done_count++;
      if (busy) busy_run++;
      else if (busy_run != 0) begin last_run = busy_run; busy_run = 0; end
      if (reset) begin
        m_active = 0; m_done = 0; m_ack = 0; m_rdata = 0;
      end else if (start && !m_active) begin
        m_active = 1; m_done = 0; m_eff = 0; m_ack = 0;
        m_abyte = {addr, rw}; m_wbyte = wdata; m_rd = rw;
        m_nack = (addr != SLAVE_ADDR);
        m_total = m_nack ? 44 : 80;
      end else if (m_active) begin
        if (!stretch) m_eff++;
        if (m_nack && m_eff / D >= 39) m_ack = 1;
        if (m_eff == m_total * D) begin
          m_active = 0; m_done = 1;
          if (!m_nack) begin
            if (m_rd) m_rdata = m_io;
            else m_io = m_wbyte;
          end
        end
      end else begin
        m_done = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_txn(input logic r, input logic [6:0] a, input logic [7:0] d,
                         input int s_at, input int s_len, input int dup_at);
    int cyc;
    bit seen;
    rw = r; addr = a; wdata = d; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    cyc = 0; seen = 0;
    while (!seen && cyc < 3000) begin
      stretch = (s_len > 0 && cyc >= s_at && cyc < s_at + s_len);
      start = (cyc == dup_at);
      @(negedge clk);
      if (done) seen = 1;
      @(posedge clk); #1; cyc++;
    end
    stretch = 1'b0; start = 1'b0;
    chk("done_seen", 32'(seen), 32'd1);
    $display("[TB] txn rw=%0d addr=0x%02h wdata=0x%02h stretch=%0d busy=%0d ack_err=%0d rdata=0x%02h",
             r, a, d, s_len, last_run, ack_err, rdata);
  endtask

  int dc;
  logic [6:0] ra;
  logic       rr;
  logic [7:0] rd8;
  int         sl, slot;

  initial begin
    reset = 1'b1; start = 1'b0; rw = 1'b0; addr = '0; wdata = '0; stretch = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_scl_oe", 32'(scl_oe), 32'd0);
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_ack_err", 32'(ack_err), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'h00);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 1: write 0xA5
    dc = done_count;
    run_txn(1'b0, 7'h01, 8'hA5, -1, 0, -1);
    chk("t1_busy_len", 32'(last_run), 32'd320);
    chk("t1_ack_err", 32'(ack_err), 32'd0);
    chk("t1_io_out", 32'(io_out), 32'hA5);
    chk("t1_done_cnt", 32'(done_count - dc), 32'd1);

    // 2: read back
    run_txn(1'b1, 7'h01, 8'h00, -1, 0, -1);
    chk("t2_rdata", 32'(rdata), 32'hA5);
    chk("t2_ack_err", 32'(ack_err), 32'd0);
    chk("t2_busy_len", 32'(last_run), 32'd320);

    // 3: address NACK
    run_txn(1'b0, 7'h22, 8'h77, -1, 0, -1);
    chk("t3_ack_err", 32'(ack_err), 32'd1);
    chk("t3_busy_len", 32'(last_run), 32'd176);
    chk("t3_io_out", 32'(io_out), 32'hA5);

    // 4: 37-cycle stretch in q1 of the slot carrying address bit 3
    run_txn(1'b0, 7'h01, 8'h5A, 21 * D, 37, -1);
    chk("t4_busy_len", 32'(last_run), 32'd357);
    chk("t4_ack_err", 32'(ack_err), 32'd0);
    chk("t4_io_out", 32'(io_out), 32'h5A);

    // 5: reset during DATA bit 4, then a clean write
    rw = 1'b0; addr = 7'h01; wdata = 8'hC3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (53 * D + 1) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1;
    chk("t5_scl_oe", 32'(scl_oe), 32'd0);
    chk("t5_sda_oe", 32'(sda_oe), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    $display("[TB] txn reset mid-write scl_oe=%0d sda_oe=%0d busy=%0d", scl_oe, sda_oe, busy);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    run_txn(1'b0, 7'h01, 8'h3C, -1, 0, -1);
    chk("t5_io_out", 32'(io_out), 32'h3C);
    chk("t5_busy_len", 32'(last_run), 32'd320);

    // 6: second start while busy is ignored
    dc = done_count;
    run_txn(1'b0, 7'h01, 8'h96, -1, 0, 10);
    chk("t6_done_cnt", 32'(done_count - dc), 32'd1);
    chk("t6_ack_err", 32'(ack_err), 32'd0);
    chk("t6_io_out", 32'(io_out), 32'h96);

    // randomized transactions
    for (int n = 0; n < 12; n++) begin
      ra  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : SLAVE_ADDR;
      rr  = 1'($urandom_range(0, 1));
      rd8 = 8'($urandom_range(0, 255));
      sl  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 20)) : 0;
      slot = int'($urandom_range(1, 8));
      run_txn(rr, ra, rd8, (4 * slot + 1) * D, sl, -1);
      chk("rnd_busy_len", 32'(last_run), 32'(((ra != SLAVE_ADDR) ? 44 : 80) * D + sl));
      chk("rnd_ack_err", 32'(ack_err), 32'(ra != SLAVE_ADDR));
      chk("rnd_io_out", 32'(io_out), 32'(m_io));
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
